// File: rtl/lcd_hd44780_responder.sv
// HD44780-side responder for the 8-bit write bus: captures bytes on E falls,
// decodes instructions, keeps AC and a 128-byte DDRAM mirror, and models BF timing.
module lcd_hd44780_responder #(
   parameter int SYNC_STAGES  = 2,
   parameter int T_BUSY_CMD   = 2000,
   parameter int T_BUSY_CLEAR = 76000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       lcd_e,
   input  logic       lcd_rs,
   input  logic       lcd_rw,
   input  logic [7:0] lcd_data,
   input  logic [6:0] rd_addr,
   output logic [7:0] rd_data,
   output logic       busy_flag,
   output logic [6:0] addr_counter,
   output logic       display_on,
   output logic       cursor_on,
   output logic       blink_on,
   output logic       entry_inc,
   output logic       entry_shift,
   output logic       func_8bit,
   output logic       func_2line,
   output logic [7:0] captured_byte,
   output logic       instr_valid,
   output logic       data_valid,
   output logic       protocol_error,
   output logic [1:0] fsm_state
);

   localparam int CW = $clog2(T_BUSY_CLEAR + 1);
   localparam logic [CW-1:0] LOAD_CMD   = CW'(T_BUSY_CMD - 1);
   localparam logic [CW-1:0] LOAD_CLEAR = CW'(T_BUSY_CLEAR - 1);

   localparam logic [1:0] S_IDLE       = 2'd0;
   localparam logic [1:0] S_DECODE     = 2'd1;
   localparam logic [1:0] S_CLEAR_FILL = 2'd2;
   localparam logic [1:0] S_BUSY       = 2'd3;

   // Valid/ready contract on the LCD bus: a byte is offered by an E falling edge;
   // the responder is ready only while busy_flag=0, anything else is rejected.
   logic [10:0]   sync_q [SYNC_STAGES];
   logic          e_s, rs_s, rw_s, e_prev;
   logic [7:0]    data_s;
   logic          e_fall, accept, reject;
   logic [1:0]    state;
   logic [CW-1:0] busy_cnt;
   logic [6:0]    fill_addr;
   logic          fill_pending;
   logic          cgram_sel;
   logic [7:0]    ddram [128];
   logic          mem_we;
   logic [6:0]    mem_waddr;
   logic [7:0]    mem_wdata;

   assign {e_s, rs_s, rw_s, data_s} = sync_q[SYNC_STAGES-1];
   assign e_fall    = e_prev & ~e_s;
   assign accept    = e_fall & ~busy_flag & ~rw_s;
   assign reject    = e_fall & (busy_flag | rw_s);
   assign fsm_state = state;

   function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc,
                                          input logic two_line);
      logic [6:0] nxt;
      nxt = inc ? ac + 7'd1 : ac - 7'd1;
      if (two_line) begin
         if (inc && ac == 7'h27)       nxt = 7'h40;
         else if (inc && ac == 7'h67)  nxt = 7'h00;
         else if (!inc && ac == 7'h40) nxt = 7'h27;
         else if (!inc && ac == 7'h00) nxt = 7'h67;
      end else begin
         if (inc && ac == 7'h4F)       nxt = 7'h00;
         else if (!inc && ac == 7'h00) nxt = 7'h4F;
      end
      return nxt;
   endfunction

   // The whole bus moves through the synchronizer as one word so rs/rw/data line up with E.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
         sync_q[0] <= {lcd_e, lcd_rs, lcd_rw, lcd_data};
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = fill_addr;
      mem_wdata = 8'h20;
      if (state == S_CLEAR_FILL) begin
         mem_we = 1'b1;
      end else if (accept && rs_s && !cgram_sel) begin
         mem_we    = 1'b1;
         mem_waddr = addr_counter;
         mem_wdata = data_s;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) ddram[mem_waddr] <= mem_wdata;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state          <= S_CLEAR_FILL;
         busy_flag      <= 1'b1;
         busy_cnt       <= LOAD_CLEAR;
         fill_addr      <= '0;
         fill_pending   <= 1'b0;
         addr_counter   <= '0;
         cgram_sel      <= 1'b0;
         display_on     <= 1'b0;
         cursor_on      <= 1'b0;
         blink_on       <= 1'b0;
         entry_inc      <= 1'b1;
         entry_shift    <= 1'b0;
         func_8bit      <= 1'b1;
         func_2line     <= 1'b0;
         captured_byte  <= '0;
         instr_valid    <= 1'b0;
         data_valid     <= 1'b0;
         protocol_error <= 1'b0;
         rd_data        <= '0;
         e_prev         <= 1'b0;
      end else begin
         e_prev         <= e_s;
         rd_data        <= ddram[rd_addr];
         instr_valid    <= 1'b0;
         data_valid     <= 1'b0;
         protocol_error <= reject;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  captured_byte <= data_s;
                  busy_flag     <= 1'b1;
                  busy_cnt      <= LOAD_CMD;
                  fill_pending  <= 1'b0;
                  state         <= S_DECODE;
                  if (rs_s) begin
                     data_valid <= 1'b1;
                     if (!cgram_sel) addr_counter <= ac_step(addr_counter, entry_inc, func_2line);
                  end else begin
                     instr_valid <= 1'b1;
                     casez (data_s)
                        8'b1???????: begin
                           addr_counter <= data_s[6:0];
                           cgram_sel    <= 1'b0;
                        end
                        8'b01??????: cgram_sel <= 1'b1;
                        8'b001?????: begin
                           func_8bit  <= data_s[4];
                           func_2line <= data_s[3];
                        end
                        8'b0001????: begin
                           // S/C=1 is a display shift, which the mirror does not model.
                           if (!data_s[3]) addr_counter <= ac_step(addr_counter, data_s[2], func_2line);
                        end
                        8'b00001???: {display_on, cursor_on, blink_on} <= data_s[2:0];
                        8'b000001??: {entry_inc, entry_shift} <= data_s[1:0];
                        8'b0000001?: begin
                           addr_counter <= '0;
                           busy_cnt     <= LOAD_CLEAR;
                        end
                        8'b00000001: begin
                           addr_counter <= '0;
                           entry_inc    <= 1'b1;
                           cgram_sel    <= 1'b0;
                           busy_cnt     <= LOAD_CLEAR;
                           fill_addr    <= '0;
                           fill_pending <= 1'b1;
                        end
                        default: ;
                     endcase
                  end
               end
            end
            S_DECODE: begin
               busy_cnt <= busy_cnt - 1'b1;
               state    <= fill_pending ? S_CLEAR_FILL : S_BUSY;
            end
            S_CLEAR_FILL: begin
               // The busy count keeps running during the fill so the total stays T_BUSY_CLEAR.
               if (busy_cnt != '0) busy_cnt <= busy_cnt - 1'b1;
               fill_addr <= fill_addr + 7'd1;
               if (fill_addr == 7'h7F) state <= S_BUSY;
            end
            S_BUSY: begin
               if (busy_cnt == '0) begin
                  busy_flag <= 1'b0;
                  state     <= S_IDLE;
               end else begin
                  busy_cnt <= busy_cnt - 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_hd44780_responder.sv
// Bench for lcd_hd44780_responder: directed bring-up sequence plus random bus traffic,
// checked against a cycle-stamped behavioural model of the display controller.
module tb_lcd_hd44780_responder;

   localparam int SYNC    = 2;
   localparam int T_CMD   = 40;
   localparam int T_CLEAR = 300;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       lcd_e = 1'b0, lcd_rs = 1'b0, lcd_rw = 1'b0;
   logic [7:0] lcd_data = 8'h00;
   logic [6:0] rd_addr = 7'h00;
   logic [7:0] rd_data, captured_byte;
   logic       busy_flag, display_on, cursor_on, blink_on, entry_inc, entry_shift;
   logic       func_8bit, func_2line, instr_valid, data_valid, protocol_error;
   logic [6:0] addr_counter;
   logic [1:0] fsm_state;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   bit mon_en = 1'b0;
   logic [7:0] exp_q[$];

   // Model: DDRAM/AC/flags plus the busy window as absolute posedge numbers.
   logic [7:0] m_ram [128];
   int   m_ac, busy_start, busy_end;
   logic m_d, m_c, m_b, m_inc, m_s, m_dl, m_n, m_cg;
   logic [7:0] m_cap;

   lcd_hd44780_responder #(
      .SYNC_STAGES(SYNC), .T_BUSY_CMD(T_CMD), .T_BUSY_CLEAR(T_CLEAR)
   ) dut (
      .clk(clk), .reset(reset), .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
      .lcd_data(lcd_data), .rd_addr(rd_addr), .rd_data(rd_data), .busy_flag(busy_flag),
      .addr_counter(addr_counter), .display_on(display_on), .cursor_on(cursor_on),
      .blink_on(blink_on), .entry_inc(entry_inc), .entry_shift(entry_shift),
      .func_8bit(func_8bit), .func_2line(func_2line), .captured_byte(captured_byte),
      .instr_valid(instr_valid), .data_valid(data_valid), .protocol_error(protocol_error),
      .fsm_state(fsm_state)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   function automatic bit m_busy(input int c);
      return (c >= busy_start) && (c < busy_end);
   endfunction

   // Valid positions are laid out as one 80-char ring (1-line) or two 40-char rows (2-line).
   function automatic int m_step(input int ac, input bit inc, input bit two);
      int pos;
      if (!two && ac < 80) return inc ? (ac + 1) % 80 : (ac + 79) % 80;
      if (two && (ac < 40 || (ac >= 64 && ac < 104))) begin
         pos = (ac >= 64) ? 40 + ac - 64 : ac;
         pos = inc ? (pos + 1) % 80 : (pos + 79) % 80;
         return (pos / 40) * 64 + pos % 40;
      end
      return inc ? (ac + 1) % 128 : (ac + 127) % 128;
   endfunction

   task automatic model_reset(input int rel);
      for (int i = 0; i < 128; i++) m_ram[i] = 8'h20;
      m_ac = 0; m_cg = 0; m_cap = 8'h00;
      {m_d, m_c, m_b} = 3'b000;
      m_inc = 1; m_s = 0; m_dl = 1; m_n = 0;
      busy_start = rel;
      busy_end   = rel + T_CLEAR;
   endtask

   task automatic model_apply(input logic rs, input logic [7:0] b, input int e0);
      m_cap = b;
      busy_start = e0;
      busy_end   = e0 + T_CMD;
      if (rs) begin
         if (!m_cg) begin
            m_ram[m_ac] = b;
            m_ac = m_step(m_ac, m_inc, m_n);
         end
      end
      else if (b >= 128) begin m_ac = int'(b) - 128; m_cg = 0; end
      else if (b >= 64)  m_cg = 1;
      else if (b >= 32)  begin m_dl = b[4]; m_n = b[3]; end
      else if (b >= 16)  begin if (!b[3]) m_ac = m_step(m_ac, b[2], m_n); end
      else if (b >= 8)   {m_d, m_c, m_b} = b[2:0];
      else if (b >= 4)   {m_inc, m_s} = b[1:0];
      else if (b >= 2)   begin m_ac = 0; busy_end = e0 + T_CLEAR; end
      else if (b == 1) begin
         m_ac = 0; m_inc = 1; m_cg = 0;
         busy_end = e0 + T_CLEAR;
         for (int i = 0; i < 128; i++) m_ram[i] = 8'h20;
      end
   endtask

   always @(negedge clk) if (mon_en) check("busy", busy_flag, m_busy(cyc));

   task automatic check_regs();
      check("ac", addr_counter, m_ac);
      check("disp", {display_on, cursor_on, blink_on}, {m_d, m_c, m_b});
      check("entry", {entry_inc, entry_shift}, {m_inc, m_s});
      check("func", {func_8bit, func_2line}, {m_dl, m_n});
      check("captured", captured_byte, m_cap);
   endtask

   task automatic wait_ready();
      while (cyc < busy_end) @(negedge clk);
      repeat ($urandom_range(0, 3)) @(negedge clk);
   endtask

   // One E pulse; the outcome pulse must land on the (SYNC+1)-th edge counting the first
   // edge that samples E low, and last exactly one cycle.
   task automatic lcd_write(input logic rs, input logic rw, input logic [7:0] b);
      int cyc0, hit_cyc, npulse;
      logic [2:0] hit_kind, exp_kind;
      logic [1:0] hit_state;
      bit acc;
      @(negedge clk);
      lcd_rs = rs; lcd_rw = rw; lcd_data = b; lcd_e = 1'b1;
      repeat (2) @(negedge clk);
      lcd_e = 1'b0;
      cyc0 = cyc;
      acc = !m_busy(cyc0 + SYNC) && !rw;
      if (acc) begin
         model_apply(rs, b, cyc0 + SYNC + 1);
         exp_kind = rs ? 3'b010 : 3'b100;
      end else begin
         exp_kind = 3'b001;
      end
      hit_cyc = -1; npulse = 0; hit_kind = '0; hit_state = '0;
      for (int k = 0; k < SYNC + 4; k++) begin
         @(negedge clk);
         if (instr_valid | data_valid | protocol_error) begin
            npulse++;
            if (hit_cyc < 0) begin
               hit_cyc   = cyc;
               hit_kind  = {instr_valid, data_valid, protocol_error};
               hit_state = fsm_state;
            end
         end
      end
      check("pulse_lat", hit_cyc - cyc0, SYNC + 1);
      check("pulse_kind", hit_kind, exp_kind);
      check("pulse_len", npulse, 1);
      if (acc) check("decode_state", hit_state, 2'd1);
   endtask

   task automatic read_all();
      for (int a = 0; a <= 128; a++) begin
         @(negedge clk);
         if (a > 0) check("rd_data", rd_data, exp_q.pop_front());
         if (a < 128) begin
            rd_addr = 7'(a);
            exp_q.push_back(m_ram[a]);
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      mon_en = 1'b0;
      reset  = 1'b0;
      @(negedge clk);
      check("rst_busy", busy_flag, 1);
      check("rst_state", fsm_state, 2'd2);
      check("rst_ac", addr_counter, 0);
      check("rst_disp", {display_on, cursor_on, blink_on}, 3'b000);
      check("rst_entry", {entry_inc, entry_shift}, 2'b10);
      check("rst_func", {func_8bit, func_2line}, 2'b10);
      check("rst_cap", captured_byte, 0);
      check("rst_pulses", {instr_valid, data_valid, protocol_error}, 3'b000);
      check("rst_rd", rd_data, 0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      model_reset(cyc);
      mon_en = 1'b1;
   endtask

   initial begin
      logic [7:0] b;
      logic rs, rw;

      do_reset();
      wait_ready();
      read_all();
      check_regs();

      // Bring-up: 8-bit 2-line, display+cursor on, increment.
      lcd_write(0, 0, 8'h38); wait_ready();
      lcd_write(0, 0, 8'h0E); wait_ready();
      lcd_write(0, 0, 8'h06);
      check("bringup", {func_2line, display_on, cursor_on, blink_on, entry_inc}, 5'b11101);
      check_regs();

      // 2-line wrap from end of row 0 into row 1.
      wait_ready(); lcd_write(0, 0, 8'hA7);
      wait_ready(); lcd_write(1, 0, 8'h41);
      wait_ready(); lcd_write(1, 0, 8'h42);
      check("ac_wrap2", addr_counter, 7'h41);
      wait_ready(); lcd_write(0, 0, 8'h10);
      wait_ready(); lcd_write(0, 0, 8'h10);
      check("ac_shift_left", addr_counter, 7'h27);

      // Decrement wrap at 0 in both line modes.
      wait_ready(); lcd_write(0, 0, 8'h04);
      wait_ready(); lcd_write(0, 0, 8'h80);
      wait_ready(); lcd_write(1, 0, 8'h5A);
      check("ac_dec2", addr_counter, 7'h67);
      wait_ready(); lcd_write(0, 0, 8'h30);
      wait_ready(); lcd_write(0, 0, 8'h80);
      wait_ready(); lcd_write(1, 0, 8'h11);
      check("ac_dec1", addr_counter, 7'h4F);
      wait_ready(); lcd_write(0, 0, 8'h06);
      wait_ready(); lcd_write(1, 0, 8'h22);
      check("ac_inc1", addr_counter, 7'h00);
      wait_ready(); lcd_write(0, 0, 8'h38);
      check_regs();

      // Rejections: mid-busy fall and a read cycle.
      wait_ready(); lcd_write(0, 0, 8'h0C);
      repeat (20) @(negedge clk);
      lcd_write(1, 0, 8'h77);
      check_regs();
      wait_ready(); lcd_write(1, 1, 8'h55);
      check_regs();
      wait_ready();
      read_all();

      // Random traffic, including CGRAM selects, reads and premature writes.
      for (int n = 0; n < 150; n++) begin
         rs = 1'($urandom_range(0, 1));
         rw = ($urandom_range(0, 9) == 0);
         b  = 8'($urandom_range(0, 255));
         if (!rs && (b == 8'h01 || b == 8'h02 || b == 8'h03)) b = b | 8'h80;
         if (!rs && $urandom_range(0, 19) == 0) b = 8'($urandom_range(1, 3));
         if ($urandom_range(0, 4) != 0) wait_ready();
         lcd_write(rs, rw, b);
         check_regs();
      end
      wait_ready();
      read_all();

      // "HI" then Clear.
      lcd_write(0, 0, 8'h80); wait_ready();
      lcd_write(1, 0, 8'h48); wait_ready();
      lcd_write(1, 0, 8'h49); wait_ready();
      lcd_write(0, 0, 8'h01);
      wait_ready();
      check("ac_clear", addr_counter, 7'h00);
      read_all();
      check_regs();

      // Reset in the middle of a clear fill restarts power-on.
      lcd_write(0, 0, 8'hE0); wait_ready();
      lcd_write(1, 0, 8'h58); wait_ready();
      lcd_write(1, 0, 8'h59); wait_ready();
      lcd_write(0, 0, 8'h01);
      repeat (47) @(negedge clk);
      do_reset();
      wait_ready();
      read_all();
      check_regs();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: cycle %0d reached, expected test end earlier", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
